aidan_mcnay_prime_ctrl: RTL and testbench
=========================================

// Module: aidan_mcnay_prime_ctrl
// PURPOSE
//  Trial-division sequencer for 16B prime detection. Accepts a candidate n and drives the
//  remainder divider one divisor at a time (opa=n, opb=d), consuming each remainder.
//  Reports is_prime plus the smallest factor found. Sits directly upstream of the divider:
//  its req port feeds the divider istream and its resp port consumes the divider ostream.
// PARAMETERS
//  nbits  16  width of candidate, divisor and remainder
// PORTS
//  clk          in   1      clock
//  reset        in   1      synchronous, active-high
//  in_n         in   nbits  candidate
//  in_val       in   1      candidate valid
//  in_rdy       out  1      ready for candidate
//  req_opa      out  nbits  dividend to divider (always n)
//  req_opb      out  nbits  divisor to divider (d)
//  req_val      out  1      divide request valid
//  req_rdy      in   1      divider ready
//  resp_rem     in   nbits  remainder n mod d
//  resp_val     in   1      remainder valid
//  resp_rdy     out  1      ready for remainder
//  out_prime    out  1      1 = n is prime
//  out_factor   out  nbits  smallest factor if composite; n if prime; 0 if n<2
//  out_val      out  1      result valid
//  out_rdy      in   1      consumer ready
// BEHAVIOUR
//  - Reset: state IDLE; n_reg, d_reg, sq_reg, out_prime, out_factor all cleared.
//    After the reset edge: in_rdy=1, req_val=0, resp_rdy=0, out_val=0, req_opa=req_opb=0.
//  - Handshakes are val&rdy transfers on the same edge. Outputs are held stable while val=1
//    and the matching rdy=0.
//  - Registers: n_reg (nbits), d_reg (nbits), sq_reg (nbits+1, always d_reg^2; no overflow
//    since (d+2)^2 < 2^(nbits+1) whenever d^2 <= n).
//  - in_rdy = (IDLE); req_val = (REQ); resp_rdy = (WAIT); out_val = (DONE).
//  - req_opa = n_reg; req_opb = d_reg (held constant for the whole request/response).
//  - FSM:
//    IDLE : on in_val: latch n; d=2, sq=4 -> CHECK. (See CONFIGURATION for odd-skip start.)
//    CHECK: n<2 -> prime=0, factor=0, DONE; sq>n -> prime=1, factor=n, DONE; else REQ.
//    REQ  : on req_rdy -> WAIT.
//    WAIT : on resp_val: rem==0 -> prime=0, factor=d, DONE;
//           else d+=step, sq+=step*(2d+step) -> CHECK.
//    DONE : on out_rdy -> IDLE (in_rdy rises the following cycle).
//  - n=2 and n=3 resolve in CHECK as prime with zero divider requests.
//  - Per-divisor latency: CHECK(1) + REQ(>=1) + divider time + WAIT accept.
//  - A resp_val arriving outside WAIT is ignored (resp_rdy=0). Exactly one request is
//    outstanding at a time.
//  - Reset mid-operation (any state) -> IDLE next edge. Any in-flight result is dropped; the
//    divider shares this reset.
// CONFIGURATION
//  PRIME_CTRL_ODD_SKIP_EN defined:
//    - IDLE->CHECK: even n>2 goes straight to DONE with prime=0, factor=2; n=2 -> prime.
//    - Odd n starts with d=3, sq=9, and step=2 (sq += 4d+4).
//  Undefined:
//    - d starts at 2, step=1 (sq += 2d+1); evens are detected by the divider.
// STRUCTURE
//  - Shared header prime_defs.v (include-guarded): state encodings IDLE/CHECK/REQ/WAIT/DONE
//    (3-bit), and a DIV_STEP constant derived from PRIME_CTRL_ODD_SKIP_EN.
//  - One sub-module, aidan_mcnay_sq_tracker: holds d_reg/sq_reg, with init/advance
//    controls and the sq>n compare.
//  - Top level holds the FSM, n_reg, result registers and handshake glue.
// TESTING (bench uses the real divider or a variable-latency behavioural model)
//  1. n=0, then n=1 -> prime=0, factor=0; no req_val ever asserted.
//  2. n=2, then n=3 -> prime=1, factor=n; zero divider requests.
//  3. n=49 -> odd-skip: requests d=3,5,7, then factor=7, prime=0.
//     Without odd-skip: d=2..7 (6 requests), then factor=7.
//  4. n=65521 -> prime=1, factor=65521. Last d=255 with odd-skip (127 requests),
//     254 requests without.
//  5. Backpressure: req_rdy low 5 cycles and out_rdy low 3 cycles -> req_opa/opb/val and
//     out_* stable, no lost or duplicated request.
//  6. Reset asserted in WAIT during n=91 -> next cycle in_rdy=1, req_val=0.
//     Then n=9 -> factor=3, prime=0.

Source files
------------

// File: rtl/aidan_mcnay_prime_ctrl_pkg.sv
// Shared definitions for the trial-division prime sequencer.
// Build option: PRIME_CTRL_ODD_SKIP_EN selects odd-only divisors (start d=3, step 2)
// with even candidates resolved without the divider.
package aidan_mcnay_prime_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StCheck = 3'd1,
        StReq   = 3'd2,
        StWait  = 3'd3,
        StDone  = 3'd4
    } state_t;

`ifdef PRIME_CTRL_ODD_SKIP_EN
    localparam int unsigned DIV_STEP = 2;
    localparam int unsigned D_INIT   = 3;
`else
    localparam int unsigned DIV_STEP = 1;
    localparam int unsigned D_INIT   = 2;
`endif

endpackage

// File: rtl/aidan_mcnay_sq_tracker.sv
// Divisor tracker: holds d and d^2, steps both incrementally, and flags d^2 > n.
// Build option: PRIME_CTRL_ODD_SKIP_EN (via the package) sets start value and step.
module aidan_mcnay_sq_tracker
    import aidan_mcnay_prime_ctrl_pkg::*;
#(
    parameter int unsigned nbits = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_init,
    input  logic             i_advance,
    input  logic [nbits-1:0] i_n,
    output logic [nbits-1:0] o_d,
    output logic             o_sq_gt_n
);

    localparam logic [nbits:0] STEP   = (nbits+1)'(DIV_STEP);
    localparam logic [nbits:0] D0     = (nbits+1)'(D_INIT);
    localparam logic [nbits:0] SQ0    = (nbits+1)'(D_INIT * D_INIT);

    logic [nbits-1:0] r_d;
    logic [nbits:0]   r_sq;
    logic [nbits:0]   w_incr;

    // (d+s)^2 - d^2 = s*(2d+s); the extra bit keeps the last step past n from wrapping
    always_comb begin
        w_incr = ({r_d, 1'b0} + STEP) * STEP;
    end

    // d/sq register: clear on reset, load start point on init, step on advance
    always_ff @(posedge clk) begin
        if (reset) begin
            r_d  <= '0;
            r_sq <= '0;
        end else if (i_init) begin
            r_d  <= D0[nbits-1:0];
            r_sq <= SQ0;
        end else if (i_advance) begin
            r_d  <= r_d + STEP[nbits-1:0];
            r_sq <= r_sq + w_incr;
        end
    end

    assign o_d       = r_d;
    assign o_sq_gt_n = (r_sq > {1'b0, i_n});

endmodule

// File: rtl/aidan_mcnay_prime_ctrl.sv
// Trial-division prime sequencer driving an external remainder divider.
// Build option: PRIME_CTRL_ODD_SKIP_EN resolves even n>2 immediately and tries odd d only.
module aidan_mcnay_prime_ctrl
    import aidan_mcnay_prime_ctrl_pkg::*;
#(
    parameter int unsigned nbits = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [nbits-1:0] in_n,
    input  logic             in_val,
    output logic             in_rdy,
    output logic [nbits-1:0] req_opa,
    output logic [nbits-1:0] req_opb,
    output logic             req_val,
    input  logic             req_rdy,
    input  logic [nbits-1:0] resp_rem,
    input  logic             resp_val,
    output logic             resp_rdy,
    output logic             out_prime,
    output logic [nbits-1:0] out_factor,
    output logic             out_val,
    input  logic             out_rdy
);

    state_t           r_state, w_state_d;
    logic [nbits-1:0] r_n, w_n_d;
    logic             r_prime, w_prime_d;
    logic [nbits-1:0] r_factor, w_factor_d;
    logic             w_init, w_advance;
    logic [nbits-1:0] w_d;
    logic             w_sq_gt_n;

    aidan_mcnay_sq_tracker #(
        .nbits (nbits)
    ) u_sq_tracker (
        .clk       (clk),
        .reset     (reset),
        .i_init    (w_init),
        .i_advance (w_advance),
        .i_n       (r_n),
        .o_d       (w_d),
        .o_sq_gt_n (w_sq_gt_n)
    );

    // State and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= StIdle;
            r_n      <= '0;
            r_prime  <= 1'b0;
            r_factor <= '0;
        end else begin
            r_state  <= w_state_d;
            r_n      <= w_n_d;
            r_prime  <= w_prime_d;
            r_factor <= w_factor_d;
        end
    end

    // Next-state and result capture
    always_comb begin
        w_state_d  = r_state;
        w_n_d      = r_n;
        w_prime_d  = r_prime;
        w_factor_d = r_factor;
        w_init     = 1'b0;
        w_advance  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (in_val) begin
                    w_n_d     = in_n;
                    w_init    = 1'b1;
                    w_state_d = StCheck;
`ifdef PRIME_CTRL_ODD_SKIP_EN
                    if (!in_n[0] && (in_n > nbits'(2))) begin
                        w_prime_d  = 1'b0;
                        w_factor_d = nbits'(2);
                        w_state_d  = StDone;
                    end
`endif
                end
            end
            StCheck: begin
                if (r_n < nbits'(2)) begin
                    w_prime_d  = 1'b0;
                    w_factor_d = '0;
                    w_state_d  = StDone;
                end else if (w_sq_gt_n) begin
                    w_prime_d  = 1'b1;
                    w_factor_d = r_n;
                    w_state_d  = StDone;
                end else begin
                    w_state_d  = StReq;
                end
            end
            StReq: begin
                if (req_rdy) w_state_d = StWait;
            end
            StWait: begin
                if (resp_val) begin
                    if (resp_rem == '0) begin
                        w_prime_d  = 1'b0;
                        w_factor_d = w_d;
                        w_state_d  = StDone;
                    end else begin
                        w_advance  = 1'b1;
                        w_state_d  = StCheck;
                    end
                end
            end
            StDone: begin
                if (out_rdy) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign in_rdy     = (r_state == StIdle);
    assign req_val    = (r_state == StReq);
    assign resp_rdy   = (r_state == StWait);
    assign out_val    = (r_state == StDone);
    assign req_opa    = r_n;
    assign req_opb    = w_d;
    assign out_prime  = r_prime;
    assign out_factor = r_factor;

endmodule

// File: tb/tb_aidan_mcnay_prime_ctrl.sv
module tb_aidan_mcnay_prime_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_n = '0;
    logic        in_val = 1'b0;
    logic        in_rdy;
    logic [15:0] req_opa, req_opb;
    logic        req_val, req_rdy;
    logic [15:0] resp_rem;
    logic        resp_val, resp_rdy;
    logic        out_prime;
    logic [15:0] out_factor;
    logic        out_val;
    logic        out_rdy = 1'b0;

    int errors = 0;
    int checks = 0;

`ifdef PRIME_CTRL_ODD_SKIP_EN
    localparam int R49 = 3, R65521 = 127, R9 = 1, R10 = 0, D49_FIRST = 3;
`else
    localparam int R49 = 6, R65521 = 254, R9 = 2, R10 = 1, D49_FIRST = 2;
`endif

    always #5 clk = ~clk;

    aidan_mcnay_prime_ctrl #(.nbits(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_n       (in_n),
        .in_val     (in_val),
        .in_rdy     (in_rdy),
        .req_opa    (req_opa),
        .req_opb    (req_opb),
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .resp_rem   (resp_rem),
        .resp_val   (resp_val),
        .resp_rdy   (resp_rdy),
        .out_prime  (out_prime),
        .out_factor (out_factor),
        .out_val    (out_val),
        .out_rdy    (out_rdy)
    );

    // Behavioural divider with varying latency
    logic        m_busy, m_resp_val, rdy_block = 1'b0;
    int          m_cnt;
    logic [15:0] m_rem;
    int          req_count = 0;
    logic [15:0] last_d = '0;

    assign req_rdy  = !m_busy && !rdy_block;
    assign resp_val = m_resp_val;
    assign resp_rem = m_rem;

    always @(posedge clk) begin
        if (reset) begin
            m_busy     <= 1'b0;
            m_resp_val <= 1'b0;
            m_cnt      <= 0;
            m_rem      <= '0;
        end else if (!m_busy && req_val && req_rdy) begin
            m_busy <= 1'b1;
            m_cnt  <= req_count % 3;
            m_rem  <= (req_opb == 0) ? 16'd0 : req_opa % req_opb;
        end else if (m_busy && !m_resp_val) begin
            if (m_cnt == 0) m_resp_val <= 1'b1;
            else m_cnt <= m_cnt - 1;
        end else if (m_resp_val && resp_rdy) begin
            m_resp_val <= 1'b0;
            m_busy     <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (!reset && req_val && req_rdy) begin
            req_count <= req_count + 1;
            last_d    <= req_opb;
        end
    end

    task automatic send_n(input logic [15:0] n);
        for (int i = 0; i < 50 && !in_rdy; i++) @(negedge clk);
        in_n   = n;
        in_val = 1'b1;
        @(negedge clk);
        in_val = 1'b0;
    endtask

    task automatic wait_out(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (out_val) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pop_out();
        out_rdy = 1'b1;
        @(negedge clk);
        out_rdy = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy got %b want 1", in_rdy); end
        checks++; if (req_val !== 1'b0) begin errors++; $display("FAIL reset_req_val got %b want 0", req_val); end
        checks++; if (resp_rdy !== 1'b0) begin errors++; $display("FAIL reset_resp_rdy got %b want 0", resp_rdy); end
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val got %b want 0", out_val); end
        checks++; if (req_opa !== 16'd0 || req_opb !== 16'd0) begin
            errors++; $display("FAIL reset_opab got %0d/%0d want 0/0", req_opa, req_opb);
        end
    endtask

    // Candidates resolved with no divider traffic: n<2 and n=2,3
    task automatic test_small();
        logic [15:0] ns[4] = '{16'd0, 16'd1, 16'd2, 16'd3};
        logic        ep[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] ef[4] = '{16'd0, 16'd0, 16'd2, 16'd3};
        logic ok;
        int   r0;
        for (int k = 0; k < 4; k++) begin
            r0 = req_count;
            send_n(ns[k]);
            wait_out(20, ok);
            checks++;
            if (!ok || out_prime !== ep[k] || out_factor !== ef[k]) begin
                errors++;
                $display("FAIL small_n%0d got ok=%b prime=%b factor=%0d want prime=%b factor=%0d",
                         ns[k], ok, out_prime, out_factor, ep[k], ef[k]);
            end
            checks++;
            if (req_count - r0 != 0) begin
                errors++; $display("FAIL small_reqs_n%0d got %0d want 0", ns[k], req_count - r0);
            end
            pop_out();
        end
    endtask

    // Composite and prime candidates going through the divider
    task automatic test_divide();
        logic [15:0] ns[4] = '{16'd49, 16'd9, 16'd10, 16'd65521};
        logic        ep[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] ef[4] = '{16'd7, 16'd3, 16'd2, 16'd65521};
        int          er[4] = '{R49, R9, R10, R65521};
        logic ok;
        int   r0;
        for (int k = 0; k < 4; k++) begin
            r0 = req_count;
            send_n(ns[k]);
            wait_out(5000, ok);
            checks++;
            if (!ok || out_prime !== ep[k] || out_factor !== ef[k]) begin
                errors++;
                $display("FAIL div_n%0d got ok=%b prime=%b factor=%0d want prime=%b factor=%0d",
                         ns[k], ok, out_prime, out_factor, ep[k], ef[k]);
            end
            checks++;
            if (req_count - r0 != er[k]) begin
                errors++; $display("FAIL div_reqs_n%0d got %0d want %0d", ns[k], req_count - r0, er[k]);
            end
            pop_out();
        end
        checks++;
        if (last_d !== 16'd255) begin
            errors++; $display("FAIL div_last_d_65521 got %0d want 255", last_d);
        end
    endtask

    task automatic test_backpressure();
        logic ok;
        int   r0;
        logic [15:0] f;
        r0 = req_count;
        rdy_block = 1'b1;
        send_n(16'd49);
        for (int i = 0; i < 20 && !req_val; i++) @(negedge clk);
        checks++;
        if (req_val !== 1'b1 || req_opa !== 16'd49 || req_opb !== 16'(D49_FIRST)) begin
            errors++; $display("FAIL bp_first_req got val=%b opa=%0d opb=%0d want 1/49/%0d",
                               req_val, req_opa, req_opb, D49_FIRST);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (req_val !== 1'b1 || req_opa !== 16'd49 || req_opb !== 16'(D49_FIRST)) begin
                errors++; $display("FAIL bp_req_hold%0d got val=%b opa=%0d opb=%0d", i,
                                   req_val, req_opa, req_opb);
            end
        end
        checks++;
        if (req_count != r0) begin
            errors++; $display("FAIL bp_no_xfer got %0d want 0", req_count - r0);
        end
        rdy_block = 1'b0;
        wait_out(500, ok);
        f = out_factor;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (!ok || out_val !== 1'b1 || out_prime !== 1'b0 || out_factor !== 16'd7) begin
                errors++; $display("FAIL bp_out_hold%0d got val=%b prime=%b factor=%0d want 1/0/7",
                                   i, out_val, out_prime, out_factor);
            end
        end
        checks++;
        if (req_count - r0 != R49 || last_d !== 16'd7) begin
            errors++; $display("FAIL bp_reqs got %0d last=%0d want %0d last=7",
                               req_count - r0, last_d, R49);
        end
        pop_out();
    endtask

    task automatic test_reset_mid();
        logic ok;
        send_n(16'd91);
        for (int i = 0; i < 50 && !resp_rdy; i++) @(negedge clk);
        checks++;
        if (resp_rdy !== 1'b1) begin errors++; $display("FAIL rm_reach_wait got %b want 1", resp_rdy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (in_rdy !== 1'b1 || req_val !== 1'b0 || out_val !== 1'b0) begin
            errors++; $display("FAIL rm_after_reset got in_rdy=%b req_val=%b out_val=%b want 1/0/0",
                               in_rdy, req_val, out_val);
        end
        send_n(16'd9);
        wait_out(200, ok);
        checks++;
        if (!ok || out_prime !== 1'b0 || out_factor !== 16'd3) begin
            errors++; $display("FAIL rm_n9 got ok=%b prime=%b factor=%0d want 0/3",
                               ok, out_prime, out_factor);
        end
        pop_out();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_small();
        test_divide();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
